// File: rtl/lockstep_pkg.sv
// ---------------------------------------------------------------------------
// lockstep_pkg
// Shared types and constants for the lockstep fault controller:
//   - lsf_state_e : controller FSM state (3-bit; encoding is visible on state_o)
//   - ERR_*       : error-code constants logged into err_log_o
//   - max3 / cnt_width : elaboration helpers for counter sizing
// ---------------------------------------------------------------------------
package lockstep_pkg;

    typedef enum logic [2:0] {
        LSF_IDLE    = 3'd0,
        LSF_RESYNC  = 3'd1,
        LSF_INJECT  = 3'd2,
        LSF_ST_WAIT = 3'd3,
        LSF_RUN     = 3'd4,
        LSF_CAPTURE = 3'd5,
        LSF_RECOVER = 3'd6,
        LSF_FATAL   = 3'd7
    } lsf_state_e;

    // Comparator error-code class prefixes (upper half-word of the code).
    localparam logic [31:0] ERR_CMP_CLASS1 = 32'h0001_0000;
    localparam logic [31:0] ERR_CMP_CLASS2 = 32'h0002_0000;
    localparam logic [31:0] ERR_CMP_CLASS3 = 32'h0003_0000;
    localparam logic [31:0] ERR_CMP_CLASS4 = 32'h0004_0000;
    // Self-test injected fault never reached the comparator output.
    localparam logic [31:0] ERR_LATENT     = 32'h0005_0000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold 0..n, never less than 1.
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lockstep_cycle_timer.sv
// ---------------------------------------------------------------------------
// lockstep_cycle_timer
// Loadable down-counter used to time the RECOVER, RESYNC and ST_WAIT phases.
// Loading N makes o_expired rise in the N-th cycle after the load edge, so a
// state that loads on entry and leaves on o_expired lasts exactly N cycles.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   i_load         load strobe (takes priority over counting)
//   i_load_val     value loaded on i_load
//   o_expired      counter currently equals 1
// ---------------------------------------------------------------------------
module lockstep_cycle_timer
    import lockstep_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == W'(1));

endmodule

// File: rtl/lockstep_fault_ctrl.sv
// ---------------------------------------------------------------------------
// lockstep_fault_ctrl
// Boot / self-test / recovery sequencer for the dual-core lockstep pair.
// Boot releases the cores, resyncs, then proves the comparator works by
// injecting a fault and waiting for it on cmp_error_i. At runtime each
// comparator error is logged and answered by core reset + resync, until the
// retry budget runs out, after which the block sits in FATAL until rst_i.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_i              leave IDLE and begin boot
//   cmp_error_i          comparator mismatch (ignored while cmp_mask_o=1)
//   cmp_error_code_i     error code, valid with cmp_error_i
//   clr_retry_i          clear the retry counter
//   inject_o             one-cycle fault-injection strobe
//   cmp_mask_o           comparator result masked
//   core_rst_o           reset request to both cores
//   run_o                pair operational and checked
//   fault_irq_o          one pulse per captured runtime error
//   fatal_o              sticky fatal
//   err_log_o, err_cnt_o last error code, saturating runtime error count
//   state_o              FSM state encoding
// ---------------------------------------------------------------------------
module lockstep_fault_ctrl
    import lockstep_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int RESYNC_CYCLES = 8,
    parameter int ST_TIMEOUT    = 4,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        cmp_error_i,
    input  logic [31:0] cmp_error_code_i,
    input  logic        clr_retry_i,
    output logic        inject_o,
    output logic        cmp_mask_o,
    output logic        core_rst_o,
    output logic        run_o,
    output logic        fault_irq_o,
    output logic        fatal_o,
    output logic [31:0] err_log_o,
    output logic [7:0]  err_cnt_o,
    output logic [2:0]  state_o
);

    localparam int TW = cnt_width(max3(RST_CYCLES, RESYNC_CYCLES, ST_TIMEOUT));
    localparam int RW = cnt_width(MAX_RETRY);

    lsf_state_e    r_state;
    lsf_state_e    w_state_nxt;
    logic          r_st_done;
    logic [RW-1:0] r_retry;
    logic [31:0]   r_err_log;
    logic [7:0]    r_err_cnt;

    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_exp;
    logic          w_cap_err;
    logic          w_log_latent;
    logic          w_st_pass;
    logic          w_retry_inc;

    lockstep_cycle_timer #(.W(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_exp)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= LSF_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state plus one-cycle strobes. The timer is loaded on the edge that
    // enters a timed state, so every timed state checks w_tmr_exp only.
    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_cap_err    = 1'b0;
        w_log_latent = 1'b0;
        w_st_pass    = 1'b0;
        w_retry_inc  = 1'b0;
        case (r_state)
            LSF_IDLE: begin
                if (start_i) begin
                    w_state_nxt = LSF_RESYNC;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(RESYNC_CYCLES);
                end
            end
            LSF_RESYNC: begin
                // Self-test is single-shot: recoveries skip straight to RUN.
                if (w_tmr_exp) w_state_nxt = r_st_done ? LSF_RUN : LSF_INJECT;
            end
            LSF_INJECT: begin
                w_state_nxt = LSF_ST_WAIT;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TW'(ST_TIMEOUT);
            end
            LSF_ST_WAIT: begin
                // A fault seen in the last allowed cycle still counts as a pass.
                if (cmp_error_i) begin
                    w_st_pass   = 1'b1;
                    w_state_nxt = LSF_RUN;
                end else if (w_tmr_exp) begin
                    w_log_latent = 1'b1;
                    w_state_nxt  = LSF_FATAL;
                end
            end
            LSF_RUN: begin
                if (cmp_error_i) begin
                    w_cap_err   = 1'b1;
                    w_state_nxt = LSF_CAPTURE;
                end
            end
            LSF_CAPTURE: begin
                if (r_retry == RW'(MAX_RETRY)) begin
                    w_state_nxt = LSF_FATAL;
                end else begin
                    w_retry_inc = 1'b1;
                    w_state_nxt = LSF_RECOVER;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(RST_CYCLES);
                end
            end
            LSF_RECOVER: begin
                if (w_tmr_exp) begin
                    w_state_nxt = LSF_RESYNC;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(RESYNC_CYCLES);
                end
            end
            LSF_FATAL: w_state_nxt = LSF_FATAL;
            default:   w_state_nxt = LSF_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st_done <= 1'b0;
            r_retry   <= '0;
            r_err_log <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_st_pass) r_st_done <= 1'b1;

            // The increment only happens in CAPTURE, so it naturally beats a
            // clear arriving in the same cycle; FATAL freezes the counter.
            if (w_retry_inc)
                r_retry <= r_retry + 1'b1;
            else if (clr_retry_i && r_state != LSF_FATAL && r_state != LSF_CAPTURE)
                r_retry <= '0;

            if (w_cap_err)         r_err_log <= cmp_error_code_i;
            else if (w_log_latent) r_err_log <= ERR_LATENT;

            if (w_cap_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign state_o     = r_state;
    assign inject_o    = (r_state == LSF_INJECT);
    assign run_o       = (r_state == LSF_RUN);
    assign fault_irq_o = (r_state == LSF_CAPTURE);
    assign fatal_o     = (r_state == LSF_FATAL);
    assign core_rst_o  = (r_state == LSF_IDLE) || (r_state == LSF_RECOVER) ||
                         (r_state == LSF_FATAL);
    assign cmp_mask_o  = (r_state == LSF_IDLE) || (r_state == LSF_RESYNC) ||
                         (r_state == LSF_CAPTURE) || (r_state == LSF_RECOVER) ||
                         (r_state == LSF_FATAL);
    assign err_log_o   = r_err_log;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_lockstep_fault_ctrl.sv
module tb_lockstep_fault_ctrl;

    localparam int RST_C = 16;
    localparam int RSY_C = 8;
    localparam int STO   = 4;
    localparam int MAXR  = 3;
    localparam logic [2:0] S_IDLE = 3'd0, S_RESYNC = 3'd1, S_INJECT = 3'd2, S_STWAIT = 3'd3;
    localparam logic [2:0] S_RUN = 3'd4, S_CAPTURE = 3'd5, S_RECOVER = 3'd6, S_FATAL = 3'd7;
    localparam logic [31:0] LATENT = 32'h0005_0000;
    // {state, core_rst, mask, run, inject, irq, fatal, err_cnt, err_log}
    localparam logic [48:0] RESET_VEC = {3'd0, 6'b110000, 8'd0, 32'd0};

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, cmp_error_i, clr_retry_i;
    logic [31:0] cmp_error_code_i;
    logic        inject_o, cmp_mask_o, core_rst_o, run_o, fault_irq_o, fatal_o;
    logic [31:0] err_log_o;
    logic [7:0]  err_cnt_o;
    logic [2:0]  state_o;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: error count/log and how many recoveries of the
    // budget have been consumed since the last effective clear.
    int          m_err_cnt;
    logic [31:0] m_err_log;
    int          m_retry_used;

    lockstep_fault_ctrl #(
        .RST_CYCLES(RST_C), .RESYNC_CYCLES(RSY_C), .ST_TIMEOUT(STO), .MAX_RETRY(MAXR)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cmp_error_i(cmp_error_i),
        .cmp_error_code_i(cmp_error_code_i), .clr_retry_i(clr_retry_i),
        .inject_o(inject_o), .cmp_mask_o(cmp_mask_o), .core_rst_o(core_rst_o),
        .run_o(run_o), .fault_irq_o(fault_irq_o), .fatal_o(fatal_o),
        .err_log_o(err_log_o), .err_cnt_o(err_cnt_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_tot);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset;
        #3 rst_i = 1'b1;
        #1;
        m_err_cnt = 0; m_err_log = '0; m_retry_used = 0;
    endtask

    task automatic release_reset;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic model_error(input logic [31:0] code, output bit fatal);
        if (m_err_cnt < 255) m_err_cnt++;
        m_err_log = code;
        if (m_retry_used >= MAXR) fatal = 1'b1;
        else begin fatal = 1'b0; m_retry_used++; end
    endtask

    // Boot: pulse start, measure RESYNC / ST_WAIT durations and inject pulses.
    // respond_at = ST_WAIT cycle (1-based) in which the injected fault shows up.
    task automatic boot(input int respond_at, output int resync_len, output int inj_cnt,
                        output int wait_len);
        resync_len = 0; inj_cnt = 0; wait_len = 0;
        start_i = 1'b1; tick(); start_i = 1'b0;
        while (state_o == S_RESYNC && resync_len < 100) begin
            inj_cnt += int'(inject_o); resync_len++; tick();
        end
        for (int j = 0; j < 10 && state_o == S_INJECT; j++) begin
            inj_cnt += int'(inject_o); tick();
        end
        while (state_o == S_STWAIT && wait_len < 100) begin
            inj_cnt += int'(inject_o); wait_len++;
            if (wait_len == respond_at) cmp_error_i = 1'b1;
            tick(); cmp_error_i = 1'b0;
        end
    endtask

    // Run from the current cycle until RUN or FATAL, counting output cycles.
    task automatic settle(input bit hold_err, output int n_cyc, output int n_mask,
                          output int n_rst, output int n_irq);
        n_cyc = 0; n_mask = 0; n_rst = 0; n_irq = 0;
        while (!(state_o == S_RUN || state_o == S_FATAL) && n_cyc < 200) begin
            n_cyc++; n_mask += int'(cmp_mask_o); n_rst += int'(core_rst_o);
            n_irq += int'(fault_irq_o);
            tick();
            clr_retry_i = 1'b0;
            cmp_error_i = hold_err && state_o != S_RUN && state_o != S_FATAL;
        end
        cmp_error_i = 1'b0;
    endtask

    // One runtime error from RUN. The code bus is scrambled right after the
    // capture edge so a late log would show up.
    task automatic fire(input logic [31:0] code, input bit clr_cap, input bit hold_err,
                        output int n_mask, output int n_rst, output int n_irq);
        int n_cyc;
        cmp_error_code_i = code; cmp_error_i = 1'b1;
        tick();
        cmp_error_i = hold_err; clr_retry_i = clr_cap; cmp_error_code_i = $urandom;
        settle(hold_err, n_cyc, n_mask, n_rst, n_irq);
    endtask

    function automatic logic [31:0] rand_code();
        return {16'($urandom_range(4, 1)), 16'($urandom)};
    endfunction

    task automatic test_reset;
        apply_reset();
        n_tot++; if ({state_o, core_rst_o, cmp_mask_o, run_o, inject_o, fault_irq_o, fatal_o, err_cnt_o, err_log_o} !== RESET_VEC)
            $display("FAIL reset_outputs: got %h want %h", {state_o, core_rst_o, cmp_mask_o, run_o, inject_o, fault_irq_o, fatal_o, err_cnt_o, err_log_o}, RESET_VEC);
        else n_pass++;
        release_reset();
        cmp_error_i = 1'b1; clr_retry_i = 1'b1;
        repeat (3) tick();
        cmp_error_i = 1'b0; clr_retry_i = 1'b0;
        n_tot++; if ({state_o, err_cnt_o} !== {S_IDLE, 8'd0})
            $display("FAIL idle_hold: got state=%0d cnt=%0d want state=0 cnt=0", state_o, err_cnt_o);
        else n_pass++;
    endtask

    task automatic test_boot_ok;
        int rl, ic, wl, irq_seen;
        irq_seen = 0;
        boot(2, rl, ic, wl);
        irq_seen += int'(fault_irq_o);
        n_tot++; if (rl !== RSY_C) $display("FAIL boot_resync_len: got %0d want %0d", rl, RSY_C); else n_pass++;
        n_tot++; if (ic !== 1) $display("FAIL boot_inject_pulses: got %0d want 1", ic); else n_pass++;
        n_tot++; if (wl !== 2) $display("FAIL boot_stwait_len: got %0d want 2", wl); else n_pass++;
        n_tot++; if ({state_o, run_o, cmp_mask_o, core_rst_o} !== {S_RUN, 3'b100})
            $display("FAIL boot_run: got state=%0d run=%b mask=%b rst=%b want 4/1/0/0", state_o, run_o, cmp_mask_o, core_rst_o);
        else n_pass++;
        repeat (3) begin tick(); irq_seen += int'(fault_irq_o); end
        n_tot++; if ({err_cnt_o, err_log_o, 8'(irq_seen)} !== {8'd0, 32'd0, 8'd0})
            $display("FAIL boot_no_log: got cnt=%0d log=%h irq=%0d want 0/0/0", err_cnt_o, err_log_o, irq_seen);
        else n_pass++;
    endtask

    task automatic test_latent;
        int rl, ic, wl;
        apply_reset(); release_reset();
        boot(STO + 5, rl, ic, wl);
        m_err_log = LATENT;
        n_tot++; if (wl !== STO) $display("FAIL latent_timeout: got %0d want %0d", wl, STO); else n_pass++;
        n_tot++; if ({state_o, fatal_o, core_rst_o, run_o, cmp_mask_o} !== {S_FATAL, 4'b1101})
            $display("FAIL latent_fatal: got state=%0d fatal=%b rst=%b run=%b mask=%b", state_o, fatal_o, core_rst_o, run_o, cmp_mask_o);
        else n_pass++;
        n_tot++; if (err_log_o !== m_err_log) $display("FAIL latent_log: got %h want %h", err_log_o, m_err_log); else n_pass++;
        start_i = 1'b1; clr_retry_i = 1'b1; cmp_error_i = 1'b1; cmp_error_code_i = rand_code();
        repeat (5) tick();
        start_i = 1'b0; clr_retry_i = 1'b0; cmp_error_i = 1'b0;
        n_tot++; if ({state_o, fatal_o, err_cnt_o, err_log_o} !== {S_FATAL, 1'b1, 8'(m_err_cnt), m_err_log})
            $display("FAIL fatal_sticky: got state=%0d fatal=%b cnt=%0d log=%h", state_o, fatal_o, err_cnt_o, err_log_o);
        else n_pass++;
    endtask

    task automatic test_runtime_error;
        int rl, ic, wl, nm, nr, ni;
        bit f;
        apply_reset(); release_reset();
        boot(1, rl, ic, wl);
        model_error(32'h0002_1234, f);
        fire(32'h0002_1234, 1'b0, 1'b0, nm, nr, ni);
        n_tot++; if (ni !== 1) $display("FAIL rt_irq_cycles: got %0d want 1", ni); else n_pass++;
        n_tot++; if (nr !== RST_C) $display("FAIL rt_core_rst_cycles: got %0d want %0d", nr, RST_C); else n_pass++;
        n_tot++; if (nm !== 1 + RST_C + RSY_C) $display("FAIL rt_mask_cycles: got %0d want %0d", nm, 1 + RST_C + RSY_C); else n_pass++;
        n_tot++; if ({state_o, run_o, err_cnt_o, err_log_o} !== {S_RUN, 1'b1, 8'(m_err_cnt), m_err_log})
            $display("FAIL rt_after: got state=%0d run=%b cnt=%0d log=%h want 4/1/%0d/%h", state_o, run_o, err_cnt_o, err_log_o, m_err_cnt, m_err_log);
        else n_pass++;
    endtask

    task automatic test_retry_budget;
        int rl, ic, wl, nm, nr, ni;
        bit f;
        logic [31:0] code;
        apply_reset(); release_reset();
        boot(3, rl, ic, wl);
        for (int e = 0; e < 4; e++) begin
            repeat ($urandom_range(4, 0)) tick();
            code = rand_code();
            model_error(code, f);
            fire(code, 1'b0, 1'b0, nm, nr, ni);
            n_tot++; if ({state_o, 8'(nr)} !== {(f ? S_FATAL : S_RUN), 8'(f ? 0 : RST_C)})
                $display("FAIL budget_err%0d: got state=%0d rst=%0d want fatal=%b", e, state_o, nr, f);
            else n_pass++;
            if (f) break;
        end
        n_tot++; if ({fatal_o, err_cnt_o, err_log_o} !== {1'b1, 8'd4, m_err_log})
            $display("FAIL budget_end: got fatal=%b cnt=%0d log=%h want 1/4/%h", fatal_o, err_cnt_o, err_log_o, m_err_log);
        else n_pass++;
        apply_reset(); release_reset();
        boot(2, rl, ic, wl);
        for (int e = 0; e < 10; e++) begin
            clr_retry_i = 1'b1; tick(); clr_retry_i = 1'b0; m_retry_used = 0;
            code = rand_code();
            model_error(code, f);
            fire(code, 1'b0, 1'b0, nm, nr, ni);
            n_tot++; if ({state_o, err_cnt_o, err_log_o} !== {(f ? S_FATAL : S_RUN), 8'(m_err_cnt), m_err_log})
                $display("FAIL clr_err%0d: got state=%0d cnt=%0d log=%h want cnt=%0d", e, state_o, err_cnt_o, err_log_o, m_err_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_masked_and_clr_capture;
        int rl, ic, wl, nm, nr, ni;
        bit f;
        logic [31:0] code;
        apply_reset(); release_reset();
        boot(4, rl, ic, wl);
        code = rand_code();
        model_error(code, f);
        fire(code, 1'b0, 1'b1, nm, nr, ni);
        n_tot++; if ({state_o, err_cnt_o, err_log_o, 8'(ni)} !== {S_RUN, 8'd1, code, 8'd1})
            $display("FAIL masked_ignore: got state=%0d cnt=%0d log=%h irq=%0d want 4/1/%h/1", state_o, err_cnt_o, err_log_o, ni, code);
        else n_pass++;
        f = 1'b0;
        for (int e = 0; e < 6 && !f; e++) begin
            code = rand_code();
            model_error(code, f);
            fire(code, 1'b1, 1'b0, nm, nr, ni);
            n_tot++; if (state_o !== (f ? S_FATAL : S_RUN))
                $display("FAIL clr_in_capture%0d: got state=%0d want %0d", e, state_o, f ? S_FATAL : S_RUN);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        int rl, ic, wl;
        apply_reset(); release_reset();
        boot(1, rl, ic, wl);
        cmp_error_code_i = rand_code(); cmp_error_i = 1'b1; tick(); cmp_error_i = 1'b0;
        repeat (5) tick();
        n_tot++; if (state_o !== S_RECOVER) $display("FAIL arst_pre_state: got %0d want %0d", state_o, S_RECOVER); else n_pass++;
        apply_reset();
        n_tot++; if ({state_o, core_rst_o, cmp_mask_o, run_o, inject_o, fault_irq_o, fatal_o, err_cnt_o, err_log_o} !== RESET_VEC)
            $display("FAIL arst_outputs: got %h want %h", {state_o, core_rst_o, cmp_mask_o, run_o, inject_o, fault_irq_o, fatal_o, err_cnt_o, err_log_o}, RESET_VEC);
        else n_pass++;
        release_reset();
        boot(3, rl, ic, wl);
        n_tot++; if ({8'(rl), 8'(ic), 8'(wl), state_o} !== {8'(RSY_C), 8'd1, 8'd3, S_RUN})
            $display("FAIL arst_reboot: got resync=%0d inj=%0d wait=%0d state=%0d", rl, ic, wl, state_o);
        else n_pass++;
    endtask

    task automatic test_random;
        int rl, ic, wl, nm, nr, ni, nerr;
        bit f, clr_cap, hold;
        logic [31:0] code;
        for (int round = 0; round < 5; round++) begin
            apply_reset(); release_reset();
            boot(int'($urandom_range(STO, 1)), rl, ic, wl);
            n_tot++; if (state_o !== S_RUN) $display("FAIL rnd%0d_boot: got state=%0d want 4", round, state_o); else n_pass++;
            nerr = int'($urandom_range(8, 2));
            for (int e = 0; e < nerr; e++) begin
                repeat ($urandom_range(4, 0)) tick();
                if ($urandom_range(3, 0) == 0) begin
                    clr_retry_i = 1'b1; tick(); clr_retry_i = 1'b0; m_retry_used = 0;
                end
                clr_cap = 1'($urandom_range(1, 0)); hold = 1'($urandom_range(1, 0));
                code = rand_code();
                model_error(code, f);
                fire(code, clr_cap, hold, nm, nr, ni);
                n_tot++; if ({state_o, 8'(nr), 8'(nm), 8'(ni)} !== {(f ? S_FATAL : S_RUN), 8'(f ? 0 : RST_C), 8'(f ? 1 : 1 + RST_C + RSY_C), 8'd1})
                    $display("FAIL rnd%0d_err%0d_seq: got state=%0d rst=%0d mask=%0d irq=%0d fatal_exp=%b", round, e, state_o, nr, nm, ni, f);
                else n_pass++;
                n_tot++; if ({err_cnt_o, err_log_o} !== {8'(m_err_cnt), m_err_log})
                    $display("FAIL rnd%0d_err%0d_log: got cnt=%0d log=%h want %0d/%h", round, e, err_cnt_o, err_log_o, m_err_cnt, m_err_log);
                else n_pass++;
                if (f) break;
            end
        end
    endtask

    task automatic test_saturation;
        int rl, ic, wl, nm, nr, ni;
        bit f;
        logic [31:0] code;
        apply_reset(); release_reset();
        boot(2, rl, ic, wl);
        for (int e = 0; e < 258; e++) begin
            clr_retry_i = 1'b1; tick(); clr_retry_i = 1'b0; m_retry_used = 0;
            code = rand_code();
            model_error(code, f);
            fire(code, 1'b0, 1'b0, nm, nr, ni);
        end
        n_tot++; if ({state_o, err_cnt_o, err_log_o} !== {S_RUN, 8'(m_err_cnt), m_err_log})
            $display("FAIL cnt_saturate: got state=%0d cnt=%0d log=%h want 4/%0d/%h", state_o, err_cnt_o, err_log_o, m_err_cnt, m_err_log);
        else n_pass++;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; cmp_error_i = 1'b0; clr_retry_i = 1'b0;
        cmp_error_code_i = '0;
        tick();
        test_reset();
        test_boot_ok();
        test_latent();
        test_runtime_error();
        test_retry_budget();
        test_masked_and_clr_capture();
        test_async_reset();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
